// File: rtl/spi_mem_loader.sv
// rtl/spi_mem_loader.sv - SPI mode-0 slave that loads words into RAM port A and holds the CPU
module spi_mem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [7:0]  CMD_WRITE  = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  cmd_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    WRITE,
    IGNORE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [ADDR_WIDTH-1:0] addr;

  // Stage [1] is the synchronised value, stage [2] its previous value for edge detection.
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic                  sclk_rise;
  logic                  cs_fall;
  logic                  cs_rise;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [ADDR_WIDTH:0]   wc_inc;

  assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2] & ~cs_sync[1];
  assign cs_fall    = ~cs_sync[1] & cs_sync[2];
  assign cs_rise    = cs_sync[1] & ~cs_sync[2];
  assign shift_next = {shift_reg[DATA_WIDTH-2:0], mosi_sync[1]};
  assign wc_inc     = (word_count == WC_MAX) ? word_count : word_count + (ADDR_WIDTH+1)'(1);

  // Two-flop synchronisers for the asynchronous SPI pins; left unreset so a reset
  // with cs_n already low does not fabricate a chip-select falling edge.
  always_ff @(posedge clock) begin
    sclk_sync <= {sclk_sync[1:0], spi_sclk};
    cs_sync   <= {cs_sync[1:0], spi_cs_n};
    mosi_sync <= {mosi_sync[0], spi_mosi};
  end

  // Frame FSM: command, address, data words, one-cycle RAM write strobes, hold/done handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      addr       <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      cmd_err    <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (state != IDLE && cs_rise) begin
        // A write already on the port finishes its bookkeeping; a partial word is dropped.
        if (state == WRITE) begin
          addr       <= addr + ADDR_WIDTH'(1);
          word_count <= wc_inc;
        end
        done     <= (state == WRITE) || (word_count != '0);
        cpu_hold <= 1'b0;
        bit_cnt  <= '0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              bit_cnt    <= '0;
              word_count <= '0;
              state      <= CMD;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_reg <= shift_next;
              if (bit_cnt == CNT_W'(7)) begin
                bit_cnt <= '0;
                if (shift_next[7:0] == CMD_WRITE) begin
                  state    <= ADDR;
                  cpu_hold <= 1'b1;
                  cmd_err  <= 1'b0;
                end else begin
                  state   <= IGNORE;
                  cmd_err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              shift_reg <= shift_next;
              if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                bit_cnt <= '0;
                addr    <= shift_next[ADDR_WIDTH-1:0];
                state   <= DATA;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_reg <= shift_next;
              if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                bit_cnt   <= '0;
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= shift_next;
                state     <= WRITE;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          WRITE: begin
            addr       <= addr + ADDR_WIDTH'(1);
            word_count <= wc_inc;
            state      <= DATA;
            // Keep the first bit of the next word if it arrives during the strobe.
            if (sclk_rise) begin
              shift_reg <= shift_next;
              bit_cnt   <= CNT_W'(1);
            end
          end
          IGNORE: begin
            state <= IGNORE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// tb/tb_spi_mem_loader.sv - self-checking bench for spi_mem_loader with a frame-level model
module tb_spi_mem_loader;

  localparam time T_HALF = 60;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic [8:0]  word_count;
  logic        cmd_err;

  always #5 clock = ~clock;

  spi_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CMD_WRITE(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .word_count (word_count),
    .cmd_err    (cmd_err)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int checks = 0;
  int failures = 0;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  wr_t  mon_w;
  int   done_cnt;
  int   wide_cnt;
  int   we_bad;
  int   hold_cycles;
  logic prev_en = 1'b0;
  logic prev_hold = 1'b0;
  logic hold_at_done;
  logic hold_before_done;
  logic hold_mid;

  logic        tx_bits[$];
  logic [31:0] wbuf[8];
  int          exp_wc;
  int          exp_done;
  logic        exp_cmd_err;

  // Observe the RAM port and handshake outputs away from the active edge.
  always @(negedge clock) begin
    if (mem_en) begin
      mon_w.a = mem_addr;
      mon_w.d = mem_wdata;
      got_q.push_back(mon_w);
      if (prev_en) wide_cnt++;
    end
    if (mem_en !== mem_we) we_bad++;
    if (done) begin
      done_cnt++;
      hold_at_done = cpu_hold;
      hold_before_done = prev_hold;
    end
    if (cpu_hold) hold_cycles++;
    prev_en = mem_en;
    prev_hold = cpu_hold;
  end

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
    wide_cnt = 0;
    we_bad = 0;
    hold_cycles = 0;
    hold_at_done = 1'bx;
    hold_before_done = 1'bx;
    hold_mid = 1'b0;
  endtask

  // Frame-level reference: the bit stream to send and what the RAM should see.
  task automatic build_frame(input logic [7:0] cmd, input logic [7:0] a, input int nw, input int npart);
    wr_t w;
    tx_bits.delete();
    exp_q.delete();
    for (int i = 7; i >= 0; i--) tx_bits.push_back(cmd[i]);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(a[i]);
    for (int k = 0; k < nw; k++)
      for (int i = 31; i >= 0; i--) tx_bits.push_back(wbuf[k][i]);
    for (int i = 0; i < npart; i++) tx_bits.push_back(1'($urandom));
    if (cmd == 8'hA5) begin
      for (int k = 0; k < nw; k++) begin
        w.a = a + 8'(k);
        w.d = wbuf[k];
        exp_q.push_back(w);
      end
      exp_wc = (nw > 256) ? 256 : nw;
      exp_cmd_err = 1'b0;
    end else begin
      exp_wc = 0;
      exp_cmd_err = 1'b1;
    end
    exp_done = (exp_wc > 0) ? 1 : 0;
  endtask

  task automatic send_frame();
    @(negedge clock);
    spi_cs_n = 1'b0;
    #T_HALF;
    foreach (tx_bits[i]) begin
      if (i == 8) hold_mid = cpu_hold;
      spi_mosi = tx_bits[i];
      #T_HALF;
      spi_sclk = 1'b1;
      #T_HALF;
      spi_sclk = 1'b0;
    end
    #T_HALF;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(4 * T_HALF);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, cmd_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got en=%b we=%b addr=%h wdata=%h hold=%b done=%b wc=%0d err=%b required all zero",
               mem_en, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, cmd_err);
    end
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_basic_frame();
    wbuf[0] = 32'h0000_1000;
    wbuf[1] = 32'h0000_1210;
    wbuf[2] = 32'h0000_9312;
    build_frame(8'hA5, 8'h00, 3, 0);
    clear_mon();
    send_frame();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_nwrites got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_write%0d got addr=%h data=%h required addr=%h data=%h", i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if (wide_cnt != 0 || we_bad != 0) begin
      failures++;
      $display("FAIL basic_strobe_width got wide=%0d we_mismatch=%0d required 0 and 0", wide_cnt, we_bad);
    end
    checks++;
    if (word_count !== 9'(exp_wc)) begin
      failures++;
      $display("FAIL basic_word_count got=%0d required=%0d", word_count, exp_wc);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done_pulses got=%0d required=1", done_cnt);
    end
    checks++;
    if ({hold_mid, hold_before_done, hold_at_done, cpu_hold} !== 4'b1100) begin
      failures++;
      $display("FAIL basic_cpu_hold got mid=%b before_done=%b at_done=%b end=%b required 1 1 0 0",
               hold_mid, hold_before_done, hold_at_done, cpu_hold);
    end
  endtask

  task automatic test_bad_cmd();
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    build_frame(8'h3C, 8'($urandom), 2, 0);
    clear_mon();
    send_frame();
    checks++;
    if (got_q.size() != 0 || done_cnt != 0 || hold_cycles != 0) begin
      failures++;
      $display("FAIL badcmd_quiet got writes=%0d done=%0d hold_cycles=%0d required 0 0 0", got_q.size(), done_cnt, hold_cycles);
    end
    checks++;
    if (cmd_err !== exp_cmd_err) begin
      failures++;
      $display("FAIL badcmd_err_set got=%b required=%b", cmd_err, exp_cmd_err);
    end
    wbuf[0] = $urandom;
    build_frame(8'hA5, 8'($urandom), 1, 0);
    clear_mon();
    send_frame();
    checks++;
    if (cmd_err !== exp_cmd_err) begin
      failures++;
      $display("FAIL badcmd_err_clear got=%b required=%b", cmd_err, exp_cmd_err);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL badcmd_followup_write got n=%0d first=%h required n=1 first=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_partial_word();
    wbuf[0] = 32'hDEAD_BEEF;
    build_frame(8'hA5, 8'h10, 1, 17);
    clear_mon();
    send_frame();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL partial_write got n=%0d first=%h required n=1 first=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
    end
    checks++;
    if (word_count !== 9'(exp_wc) || done_cnt != 1) begin
      failures++;
      $display("FAIL partial_count got wc=%0d done=%0d required wc=%0d done=1", word_count, done_cnt, exp_wc);
    end
  endtask

  task automatic test_addr_wrap();
    wbuf[0] = 32'h1111_1111;
    wbuf[1] = 32'h2222_2222;
    build_frame(8'hA5, 8'hFF, 2, 0);
    clear_mon();
    send_frame();
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL wrap_nwrites got=%0d required=2", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wrap_write%0d got addr=%h data=%h required addr=%h data=%h", i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if (word_count !== 9'(exp_wc)) begin
      failures++;
      $display("FAIL wrap_word_count got=%0d required=%0d", word_count, exp_wc);
    end
  endtask

  task automatic test_no_words();
    build_frame(8'hA5, 8'h00, 0, 0);
    clear_mon();
    send_frame();
    checks++;
    if (got_q.size() != 0 || done_cnt != 0) begin
      failures++;
      $display("FAIL nowords_quiet got writes=%0d done=%0d required 0 0", got_q.size(), done_cnt);
    end
    checks++;
    if ({hold_mid, cpu_hold} !== 2'b10) begin
      failures++;
      $display("FAIL nowords_hold got mid=%b end=%b required 1 0", hold_mid, cpu_hold);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 3; k++) wbuf[k] = $urandom | 32'h1;
    build_frame(8'hA5, 8'($urandom_range(1, 255)), 3, 0);
    clear_mon();
    fork
      send_frame();
      begin
        #(T_HALF * 117);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, cmd_err} !== '0) begin
          failures++;
          $display("FAIL midreset_outputs got en=%b we=%b addr=%h wdata=%h hold=%b done=%b wc=%0d err=%b required all zero",
                   mem_en, mem_we, mem_addr, mem_wdata, cpu_hold, done, word_count, cmd_err);
        end
        got_q.delete();
        done_cnt = 0;
        hold_cycles = 0;
        reset = 1'b1;
      end
    join
    checks++;
    if (got_q.size() != 0 || done_cnt != 0 || hold_cycles != 0) begin
      failures++;
      $display("FAIL midreset_after got writes=%0d done=%0d hold_cycles=%0d required 0 0 0", got_q.size(), done_cnt, hold_cycles);
    end
    wbuf[0] = 32'h0000_0001;
    build_frame(8'hA5, 8'h05, 1, 0);
    clear_mon();
    send_frame();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || done_cnt != 1) begin
      failures++;
      $display("FAIL midreset_recover got n=%0d first=%h done=%0d required n=1 first=%h done=1",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, done_cnt, exp_q[0]);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] cmd;
    int nw;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        do cmd = 8'($urandom); while (cmd == 8'hA5);
      end else begin
        cmd = 8'hA5;
      end
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) wbuf[k] = $urandom;
      build_frame(cmd, 8'($urandom), nw, $urandom_range(0, 31));
      clear_mon();
      send_frame();
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_nwrites got=%0d required=%0d", f, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_write%0d got addr=%h data=%h required addr=%h data=%h", f, i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
        end
      end
      checks++;
      if (word_count !== 9'(exp_wc) || done_cnt != exp_done || cmd_err !== exp_cmd_err || wide_cnt != 0) begin
        failures++;
        $display("FAIL rand%0d_status got wc=%0d done=%0d err=%b wide=%0d required wc=%0d done=%0d err=%b wide=0",
                 f, word_count, done_cnt, cmd_err, wide_cnt, exp_wc, exp_done, exp_cmd_err);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_frame();
    test_bad_cmd();
    test_partial_word();
    test_addr_wrap();
    test_no_words();
    test_reset_mid_frame();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_loader.md
Name: spi_mem_loader

Overview:
- SPI slave (mode 0, MSB first) that receives program/data words from an external host and writes them into port A of the processor's dual-port RAM.
- Sits directly upstream of the memory/processor pair and replaces bench-driven port-A writes.
- Asserts cpu_hold while a load frame is active so the processor is held off until the image is complete.

Parameters:
- ADDR_WIDTH, 8: RAM address width.
- DATA_WIDTH, 32: RAM word width; bits shifted per word.
- CMD_WRITE, 8'hA5: command byte that opens a write frame.

Ports:
- clock, input, 1: system clock, all logic on rising edge.
- reset, input, 1: synchronous, active-low reset; reset=0 resets on the next clock edge.
- spi_sclk, input, 1: SPI clock, asynchronous to clock.
- spi_cs_n, input, 1: SPI chip select, active-low, asynchronous.
- spi_mosi, input, 1: SPI data in, asynchronous.
- mem_en, output, 1: RAM port A enable.
- mem_we, output, 1: RAM port A write enable.
- mem_addr, output, ADDR_WIDTH: RAM port A address.
- mem_wdata, output, DATA_WIDTH: RAM port A write data.
- cpu_hold, output, 1: processor must stall while high.
- done, output, 1: one-cycle pulse when a frame ends having written at least 1 word.
- word_count, output, ADDR_WIDTH+1: number of words written in the current or last frame.
- cmd_err, output, 1: sticky flag, set on an invalid command byte.

Behaviour:
- Clocking constraint: f(clock) >= 8 x f(spi_sclk). The bench is not required to check violations of this.
- Synchronisers: spi_sclk, spi_cs_n and spi_mosi each pass through a 2-FF synchroniser.
- Edge detect: a sclk rise is synchronised sclk 0->1 with synchronised cs_n=0. On each sclk rise, shift the synchronised mosi into the LSB of the shift register.
- Pin-to-sample latency: 3 clocks.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, word_count=0, cmd_err=0. State goes to IDLE and the bit counter to 0.
- Reset mid-frame: the frame is dropped, and the block waits in IDLE for a new cs_n falling edge.
- FSM states: IDLE, CMD, ADDR, DATA, WRITE, IGNORE.
- IDLE -> CMD: on a synchronised cs_n falling edge. Clear the bit counter and word_count.
- CMD: collect 8 bits.
  - If the byte equals CMD_WRITE: go to ADDR, set cpu_hold=1, clear cmd_err.
  - Otherwise: go to IGNORE and set cmd_err=1.
- ADDR: collect ADDR_WIDTH bits and load them into the address register, then go to DATA.
- DATA: collect DATA_WIDTH bits. After the final bit, go to WRITE in the next cycle.
- WRITE (exactly one cycle):
  - Drive mem_en=1, mem_we=1, mem_addr=current address, mem_wdata=assembled word.
  - In the following cycle, increment the address (modulo 2^ADDR_WIDTH, so 8'hFF wraps to 8'h00) and increment word_count, saturating at 2^ADDR_WIDTH.
  - Return to DATA.
- Outside WRITE: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- IGNORE: disregard all sclk edges until cs_n deasserts.
- Synchronised cs_n rising edge, from any non-IDLE state:
  - Return to IDLE and discard any partial word; a partial word never produces a write.
  - If WRITE is active in that same cycle, the write completes first.
  - cpu_hold drops one cycle after the cs_n rise is detected.
  - done pulses for 1 cycle, in the same cycle cpu_hold drops, only if word_count > 0.
- word_count holds its value after the frame ends and clears at the next frame start.
- sclk edges while cs_n=1 are ignored.

Test Plan:
- Frame A5, 00, 00001000, 00001210, 00009312 -> three write strobes:
  - addr 00 with 00001000;
  - addr 01 with 00001210;
  - addr 02 with 00009312.
  - Each strobe is exactly 1 cycle wide.
  - word_count=3, one done pulse, cpu_hold high from the command byte until 1 cycle after cs_n rises.
- Frame with command 3C and 2 words -> no mem_en at all, cmd_err=1, cpu_hold stays 0, no done.
  - A following valid A5 frame clears cmd_err.
- Frame A5, 10, one full word DEADBEEF, then 17 bits of a second word, then cs_n high -> exactly one write (addr 10 with DEADBEEF), word_count=1, one done pulse.
- Frame A5, FF, 2 words 11111111 and 22222222 -> writes at addr FF then addr 00 (wrap), word_count=2.
- Frame A5, 00, cs_n high before any word completes -> no writes, no done pulse, cpu_hold drops.
- reset=0 for 1 cycle midway through the 2nd data word of an A5 frame -> all outputs return to reset values and no further writes occur.
  - A new A5, 05, 00000001 frame then writes addr 05 correctly.
